// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
//   - uart_state_e : frame FSM states
//   - START_BIT / STOP_BIT : line levels of the framing bits
//   - PAR_EVEN / PAR_ODD   : PAR_TYP encoding
//   - PRESCALE_*           : legal oversampling ratios
//   - prescale_norm()      : maps any Prescale value onto a legal ratio
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  // Anything other than 16 or 32 falls back to 8.
  function automatic logic [5:0] prescale_norm(input logic [5:0] p);
    case (p)
      PRESCALE_16: return PRESCALE_16;
      PRESCALE_32: return PRESCALE_32;
      default:     return PRESCALE_8;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Line-side and host-side signals of the UART receiver.
//   slave  : the receiver (consumes line + config, produces byte + flags)
//   master : whoever drives the line and reads the byte
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  RX_IN;
  logic [5:0]            Prescale;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  Par_Err;
  logic                  Stp_Err;

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP,
    output P_DATA, Data_Valid, Par_Err, Stp_Err
  );

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP,
    input  P_DATA, Data_Valid, Par_Err, Stp_Err
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Three-point mid-bit sampler with 2-of-3 majority vote.
//   CLK, RST   : clock, async active-low reset
//   rx_in      : serial line
//   edge_cnt   : position inside the current bit (0..P-1)
//   prescale   : latched oversampling ratio P
//   maj        : majority of the samples taken at P/2-1, P/2, P/2+1;
//                meaningful from edge_cnt P/2+2 until the next bit's samples
module uart_rx_sampler (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rx_in,
  input  logic [5:0] edge_cnt,
  input  logic [5:0] prescale,
  output logic       maj
);

  logic [2:0] smp_q, smp_d;
  logic [5:0] mid;

  assign mid = {1'b0, prescale[5:1]};

  always_comb begin
    smp_d = smp_q;
    if (edge_cnt == mid - 6'd1) smp_d[0] = rx_in;
    if (edge_cnt == mid)        smp_d[1] = rx_in;
    if (edge_cnt == mid + 6'd1) smp_d[2] = rx_in;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) smp_q <= 3'b111;
    else      smp_q <= smp_d;
  end

  assign maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detect, oversampled bit timing, LSB-first
// deserialization, parity and stop checks.
//   CLK, RST : oversampling clock, async active-low reset
//   bus      : uart_rx_if slave
//              in : RX_IN, Prescale, PAR_EN, PAR_TYP
//              out: P_DATA, Data_Valid (1-cycle pulse), Par_Err, Stp_Err
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic     CLK,
  input  logic     RST,
  uart_rx_if.slave bus
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [5:0]            edge_cnt_q, edge_cnt_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [5:0]            presc_q, presc_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  dv_q, dv_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;

  logic maj;
  logic edge_last;
  logic par_exp;

  uart_rx_sampler u_sampler (
    .CLK      (CLK),
    .RST      (RST),
    .rx_in    (bus.RX_IN),
    .edge_cnt (edge_cnt_q),
    .prescale (presc_q),
    .maj      (maj)
  );

  assign edge_last = (edge_cnt_q == presc_q - 6'd1);
  assign par_exp   = (par_typ_q == PAR_EVEN) ? ^shift_q : ~^shift_q;

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_last ? 6'd0 : edge_cnt_q + 6'd1;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    presc_d    = presc_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    p_data_d   = p_data_q;
    dv_d       = 1'b0;
    par_err_d  = par_err_q;
    stp_err_d  = stp_err_q;

    case (state_q)
      IDLE: begin
        edge_cnt_d = 6'd0;
        bit_cnt_d  = 3'd0;
        if (bus.RX_IN == START_BIT) begin
          // The detecting edge is edge 0 of the start bit, so continue at 1.
          state_d    = START;
          edge_cnt_d = 6'd1;
          presc_d    = prescale_norm(bus.Prescale);
          par_en_d   = bus.PAR_EN;
          par_typ_d  = bus.PAR_TYP;
          par_err_d  = 1'b0;
          stp_err_d  = 1'b0;
        end
      end
      START: begin
        if (edge_last) state_d = (maj == START_BIT) ? DATA : IDLE;
      end
      DATA: begin
        if (edge_last) begin
          shift_d   = {maj, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (edge_last) begin
          if (maj != par_exp) par_err_d = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (edge_last) begin
          if (maj != STOP_BIT) stp_err_d = 1'b1;
          if (!par_err_q && maj == STOP_BIT) begin
            p_data_d = shift_q;
            dv_d     = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        edge_cnt_d = 6'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      edge_cnt_q <= 6'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= '0;
      presc_q    <= PRESCALE_8;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      presc_q    <= presc_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
    end
  end

  assign bus.P_DATA     = p_data_q;
  assign bus.Data_Valid = dv_q;
  assign bus.Par_Err    = par_err_q;
  assign bus.Stp_Err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx. Cycle k is the clock period ending at
// rising edge k, with the start-detect edge as edge 0; outputs are
// sampled on the falling edge inside that period.
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   pos_cnt = 0;
  int   dv_cyc[$];
  logic [7:0] dv_dat[$];

  uart_rx_if #(.DATA_WIDTH(8)) bus ();

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pos_cnt <= pos_cnt + 1;

  always @(negedge clk) begin
    if (bus.Data_Valid === 1'b1) begin
      dv_cyc.push_back(pos_cnt);
      dv_dat.push_back(bus.P_DATA);
    end
  end

  task automatic idle(input int n);
    bus.RX_IN = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int p);
    bus.RX_IN = v;
    repeat (p) @(negedge clk);
  endtask

  // One bit with a single inverted cycle at position pos.
  task automatic drive_spike(input logic v, input int p, input int pos);
    for (int k = 0; k < p; k++) begin
      bus.RX_IN = (k == pos) ? ~v : v;
      @(negedge clk);
    end
  endtask

  // Data, optional parity and stop bits; start bit already sent.
  task automatic send_body(input logic [7:0] d, input int p, input logic pe,
                           input logic pb, input logic sb);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (pe) drive_bit(pb, p);
    drive_bit(sb, p);
    bus.RX_IN = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.RX_IN = 1'b1; bus.Prescale = 6'd8; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.P_DATA !== 8'h00) begin n_err++; $display("FAIL rst_pdata got %h want 00", bus.P_DATA); end
    n_cmp++; if (bus.Data_Valid !== 1'b0) begin n_err++; $display("FAIL rst_dv got %b want 0", bus.Data_Valid); end
    n_cmp++; if (bus.Par_Err !== 1'b0) begin n_err++; $display("FAIL rst_parerr got %b want 0", bus.Par_Err); end
    n_cmp++; if (bus.Stp_Err !== 1'b0) begin n_err++; $display("FAIL rst_stperr got %b want 0", bus.Stp_Err); end
    rst = 1'b1;
    idle(3);
  endtask

  task automatic test_p8_noparity();
    int base, t0;
    base = dv_cyc.size();
    bus.Prescale = 6'd8; bus.PAR_EN = 1'b0;
    t0 = pos_cnt;
    drive_bit(1'b0, 8);
    send_body(8'hF8, 8, 1'b0, 1'b0, 1'b1);
    idle(4);
    n_cmp++; if (dv_cyc.size() - base !== 1) begin n_err++; $display("FAIL p8_pulses got %0d want 1", dv_cyc.size() - base); end
    if (dv_cyc.size() > base) begin
      n_cmp++; if (dv_cyc[base] - t0 !== 80) begin n_err++; $display("FAIL p8_cycle got %0d want 80", dv_cyc[base] - t0); end
      n_cmp++; if (dv_dat[base] !== 8'hF8) begin n_err++; $display("FAIL p8_pulse_data got %h want f8", dv_dat[base]); end
    end
    n_cmp++; if (bus.P_DATA !== 8'hF8) begin n_err++; $display("FAIL p8_pdata got %h want f8", bus.P_DATA); end
    n_cmp++; if ({bus.Par_Err, bus.Stp_Err} !== 2'b00) begin n_err++; $display("FAIL p8_flags got %b want 00", {bus.Par_Err, bus.Stp_Err}); end
  endtask

  task automatic test_parity_even();
    int base, t0;
    base = dv_cyc.size();
    bus.Prescale = 6'd16; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0;
    t0 = pos_cnt;
    drive_bit(1'b0, 16);
    send_body(8'h6F, 16, 1'b1, 1'b0, 1'b1);
    idle(4);
    n_cmp++; if (dv_cyc.size() - base !== 1) begin n_err++; $display("FAIL pe_pulses got %0d want 1", dv_cyc.size() - base); end
    if (dv_cyc.size() > base) begin
      n_cmp++; if (dv_cyc[base] - t0 !== 176) begin n_err++; $display("FAIL pe_cycle got %0d want 176", dv_cyc[base] - t0); end
    end
    n_cmp++; if (bus.P_DATA !== 8'h6F) begin n_err++; $display("FAIL pe_pdata got %h want 6f", bus.P_DATA); end
    n_cmp++; if (bus.Par_Err !== 1'b0) begin n_err++; $display("FAIL pe_parerr got %b want 0", bus.Par_Err); end
    // Wrong parity bit; line byte differs so an unguarded load would show.
    base = dv_cyc.size();
    drive_bit(1'b0, 16);
    send_body(8'h6E, 16, 1'b1, 1'b0, 1'b1);
    idle(4);
    n_cmp++; if (bus.Par_Err !== 1'b1) begin n_err++; $display("FAIL pe_bad_parerr got %b want 1", bus.Par_Err); end
    n_cmp++; if (dv_cyc.size() - base !== 0) begin n_err++; $display("FAIL pe_bad_pulses got %0d want 0", dv_cyc.size() - base); end
    n_cmp++; if (bus.P_DATA !== 8'h6F) begin n_err++; $display("FAIL pe_bad_pdata got %h want 6f", bus.P_DATA); end
    n_cmp++; if (bus.Stp_Err !== 1'b0) begin n_err++; $display("FAIL pe_bad_stperr got %b want 0", bus.Stp_Err); end
  endtask

  task automatic test_stop_err_odd();
    int base;
    base = dv_cyc.size();
    bus.Prescale = 6'd32; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b1;
    drive_bit(1'b0, 32);
    send_body(8'h5D, 32, 1'b1, 1'b0, 1'b0);
    idle(4);
    n_cmp++; if (bus.Stp_Err !== 1'b1) begin n_err++; $display("FAIL se_stperr got %b want 1", bus.Stp_Err); end
    n_cmp++; if (bus.Par_Err !== 1'b0) begin n_err++; $display("FAIL se_parerr got %b want 0", bus.Par_Err); end
    n_cmp++; if (dv_cyc.size() - base !== 0) begin n_err++; $display("FAIL se_pulses got %0d want 0", dv_cyc.size() - base); end
    // Next frame: flags must drop as soon as its start is detected.
    drive_bit(1'b0, 32);
    n_cmp++; if ({bus.Par_Err, bus.Stp_Err} !== 2'b00) begin n_err++; $display("FAIL se_clear got %b want 00", {bus.Par_Err, bus.Stp_Err}); end
    n_cmp++; if (bus.P_DATA !== 8'h6F) begin n_err++; $display("FAIL se_held got %h want 6f", bus.P_DATA); end
    send_body(8'h78, 32, 1'b1, 1'b1, 1'b1);
    idle(4);
    n_cmp++; if (bus.P_DATA !== 8'h78) begin n_err++; $display("FAIL se_next_pdata got %h want 78", bus.P_DATA); end
    n_cmp++; if (dv_cyc.size() - base !== 1) begin n_err++; $display("FAIL se_next_pulses got %0d want 1", dv_cyc.size() - base); end
    n_cmp++; if ({bus.Par_Err, bus.Stp_Err} !== 2'b00) begin n_err++; $display("FAIL se_next_flags got %b want 00", {bus.Par_Err, bus.Stp_Err}); end
  endtask

  task automatic test_glitch_spikes();
    int base, t0;
    logic [7:0] d;
    base = dv_cyc.size();
    bus.Prescale = 6'd8; bus.PAR_EN = 1'b0;
    t0 = pos_cnt;
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 6);
    n_cmp++; if (dv_cyc.size() - base !== 0) begin n_err++; $display("FAIL gl_pulses got %0d want 0", dv_cyc.size() - base); end
    n_cmp++; if ({bus.Par_Err, bus.Stp_Err} !== 2'b00) begin n_err++; $display("FAIL gl_flags got %b want 00", {bus.Par_Err, bus.Stp_Err}); end
    // Frame starts at cycle 8; illegal prescale 5 behaves as 8.
    bus.Prescale = 6'd5;
    t0 = pos_cnt;
    d = 8'h96;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 8; i++) drive_spike(d[i], 8, (i % 2 == 1) ? 4 : 1);
    drive_spike(1'b1, 8, 6);
    idle(4);
    n_cmp++; if (dv_cyc.size() - base !== 1) begin n_err++; $display("FAIL sp_pulses got %0d want 1", dv_cyc.size() - base); end
    if (dv_cyc.size() > base) begin
      n_cmp++; if (dv_cyc[base] - t0 !== 80) begin n_err++; $display("FAIL sp_cycle got %0d want 80", dv_cyc[base] - t0); end
    end
    n_cmp++; if (bus.P_DATA !== 8'h96) begin n_err++; $display("FAIL sp_pdata got %h want 96", bus.P_DATA); end
  endtask

  task automatic test_back_to_back();
    int base, t0;
    base = dv_cyc.size();
    bus.Prescale = 6'd16; bus.PAR_EN = 1'b0;
    t0 = pos_cnt;
    drive_bit(1'b0, 16);
    send_body(8'h6F, 16, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b0, 16);
    send_body(8'h78, 16, 1'b0, 1'b0, 1'b1);
    idle(4);
    n_cmp++; if (dv_cyc.size() - base !== 2) begin n_err++; $display("FAIL b2b_pulses got %0d want 2", dv_cyc.size() - base); end
    if (dv_cyc.size() >= base + 2) begin
      n_cmp++; if (dv_cyc[base] - t0 !== 160) begin n_err++; $display("FAIL b2b_cyc0 got %0d want 160", dv_cyc[base] - t0); end
      n_cmp++; if (dv_cyc[base+1] - t0 !== 320) begin n_err++; $display("FAIL b2b_cyc1 got %0d want 320", dv_cyc[base+1] - t0); end
      n_cmp++; if (dv_dat[base] !== 8'h6F) begin n_err++; $display("FAIL b2b_dat0 got %h want 6f", dv_dat[base]); end
      n_cmp++; if (dv_dat[base+1] !== 8'h78) begin n_err++; $display("FAIL b2b_dat1 got %h want 78", dv_dat[base+1]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int base, t0;
    logic [7:0] d;
    base = dv_cyc.size();
    bus.Prescale = 6'd16; bus.PAR_EN = 1'b0;
    d = 8'hA5;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) drive_bit(d[i], 16);
    drive_bit(d[3], 8);
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.P_DATA !== 8'h00) begin n_err++; $display("FAIL mr_pdata got %h want 00", bus.P_DATA); end
    n_cmp++; if (bus.Data_Valid !== 1'b0) begin n_err++; $display("FAIL mr_dv got %b want 0", bus.Data_Valid); end
    n_cmp++; if ({bus.Par_Err, bus.Stp_Err} !== 2'b00) begin n_err++; $display("FAIL mr_flags got %b want 00", {bus.Par_Err, bus.Stp_Err}); end
    drive_bit(d[3], 8);
    drive_bit(d[4], 16);
    rst = 1'b1;
    idle(4);
    t0 = pos_cnt;
    drive_bit(1'b0, 16);
    send_body(8'h3C, 16, 1'b0, 1'b0, 1'b1);
    idle(4);
    n_cmp++; if (bus.P_DATA !== 8'h3C) begin n_err++; $display("FAIL mr_next_pdata got %h want 3c", bus.P_DATA); end
    n_cmp++; if (dv_cyc.size() - base !== 1) begin n_err++; $display("FAIL mr_pulses got %0d want 1", dv_cyc.size() - base); end
    if (dv_cyc.size() > base) begin
      n_cmp++; if (dv_cyc[base] - t0 !== 160) begin n_err++; $display("FAIL mr_cycle got %0d want 160", dv_cyc[base] - t0); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_p8_noparity();
    test_parity_even();
    test_stop_err_odd();
    test_glitch_spikes();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
